// File: rtl/vga_line_prefetch.sv
// vga_line_prefetch: prefetches one 1bpp line from SRAM ahead of display into a double-buffered line store (VGA_PREFETCH_BITREV_EN bit-reverses captured words)
module vga_line_prefetch #(
  parameter int WORDS_PER_LINE = 20,
  parameter int LINES = 480,
  parameter int FB_BASE = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        frame_start,
  input  logic        line_done,
  input  logic [4:0]  rd_word_idx,
  output logic [31:0] rd_word,
  output logic        line_ready,
  output logic        underrun,
  input  logic [31:0] SRAM_data_in,
  input  logic        SRAM_busy,
  output logic [31:0] word_address_dest,
  output logic [3:0]  byte_select,
  output logic        read_en
);
  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;
  localparam logic [4:0] WPL = 5'(WORDS_PER_LINE);
  localparam logic [4:0] LAST = 5'(WORDS_PER_LINE - 1);
  localparam logic [8:0] NLINES = 9'(LINES);
  state_t state_q, state_d;
  logic sel_q, sel_d, front_valid_q, front_valid_d, underrun_q, underrun_d;
  logic [8:0] fetch_line_q, fetch_line_d, next_line;
  logic [4:0] idx_q, idx_d;
  logic [31:0] rd_word_q, rd_word_d, cap_word;
  logic [31:0] buf_q [2][WORDS_PER_LINE];
  logic [31:0] buf_d [2][WORDS_PER_LINE];
`ifdef VGA_PREFETCH_BITREV_EN
  always_comb cap_word = {<<{SRAM_data_in}};
`else
  always_comb cap_word = SRAM_data_in;
`endif
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    front_valid_d = front_valid_q;
    fetch_line_d = fetch_line_q;
    idx_d = idx_q;
    buf_d = buf_q;
    underrun_d = 1'b0;
    next_line = fetch_line_q + 9'd1;
    rd_word_d = (front_valid_q && rd_word_idx < WPL) ? buf_q[sel_q][rd_word_idx] : '0;
    if (frame_start) begin
      fetch_line_d = '0;
      idx_d = '0;
      front_valid_d = 1'b0;
      state_d = FETCH;
    end else if (state_q == FETCH) begin
      if (line_done) begin
        underrun_d = 1'b1;
        front_valid_d = 1'b0;
      end
      if (!SRAM_busy) begin
        buf_d[~sel_q][idx_q] = cap_word;
        idx_d = (idx_q == LAST) ? '0 : idx_q + 5'd1;
        state_d = (idx_q == LAST) ? FULL : FETCH;
      end
    end else if (state_q == FULL) begin
      if (line_done || !front_valid_q) begin
        sel_d = ~sel_q;
        front_valid_d = 1'b1;
        fetch_line_d = next_line;
        state_d = (next_line < NLINES) ? FETCH : IDLE;
      end
    end else if (line_done && fetch_line_q >= NLINES) begin
      front_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      front_valid_q <= 1'b0;
      fetch_line_q <= '0;
      idx_q <= '0;
      rd_word_q <= '0;
      underrun_q <= 1'b0;
      buf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      front_valid_q <= front_valid_d;
      fetch_line_q <= fetch_line_d;
      idx_q <= idx_d;
      rd_word_q <= rd_word_d;
      underrun_q <= underrun_d;
      buf_q <= buf_d;
    end
  end
  assign read_en = state_q == FETCH;
  assign byte_select = {4{read_en}};
  assign word_address_dest = read_en ? 32'(FB_BASE) + 32'(fetch_line_q) * 32'(WORDS_PER_LINE) + 32'(idx_q) : '0;
  assign rd_word = rd_word_q;
  assign line_ready = front_valid_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_vga_line_prefetch.sv
// tb_vga_line_prefetch: scoreboard bench for vga_line_prefetch address stream, read port and frame control
module tb_vga_line_prefetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst = 1'b0, frame_start = 1'b0, line_done = 1'b0, SRAM_busy = 1'b0;
  logic [4:0] rd_word_idx = '0;
  logic [31:0] rd_word, word_address_dest, sram_data;
  logic [3:0] byte_select;
  logic line_ready, underrun, read_en;
  logic fs2 = 1'b0, ld2 = 1'b0, busy2 = 1'b0;
  logic [31:0] rd_word2, addr2, data2;
  logic [3:0] bs2;
  logic line_ready2, underrun2, re2;
  assign sram_data = 32'h1000_0000 + word_address_dest;
  assign data2 = 32'h1000_0000 + addr2;
  vga_line_prefetch u1 (
    .clk(clk), .nrst(nrst), .frame_start(frame_start), .line_done(line_done),
    .rd_word_idx(rd_word_idx), .rd_word(rd_word), .line_ready(line_ready), .underrun(underrun),
    .SRAM_data_in(sram_data), .SRAM_busy(SRAM_busy), .word_address_dest(word_address_dest),
    .byte_select(byte_select), .read_en(read_en)
  );
  vga_line_prefetch #(.LINES(2)) u2 (
    .clk(clk), .nrst(nrst), .frame_start(fs2), .line_done(ld2),
    .rd_word_idx(rd_word_idx), .rd_word(rd_word2), .line_ready(line_ready2), .underrun(underrun2),
    .SRAM_data_in(data2), .SRAM_busy(busy2), .word_address_dest(addr2),
    .byte_select(bs2), .read_en(re2)
  );
  int tests = 0, fails = 0;
  bit mon_en = 1'b0;
  logic [31:0] addr_q[$], rd_q[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mon_en && read_en && !SRAM_busy) begin
      if (addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL addr_unexpected: got %h, expected no read", word_address_dest);
      end else check("addr", word_address_dest, addr_q.pop_front());
    end
    if (rd_q.size() != 0) check("rd_word", rd_word, rd_q.pop_front());
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask
  task automatic pulse_ld();
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
  endtask
  task automatic expect_addrs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) addr_q.push_back(32'(i));
    mon_en = 1'b1;
  endtask
  task automatic wait_drain(input string name);
    int k = 0;
    while (addr_q.size() != 0 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, 32'(addr_q.size()), 32'd0);
    mon_en = 1'b0;
  endtask
  task automatic wait_addr(input logic [31:0] a);
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(read_en && word_address_dest == a) && k < 300);
    check("wait_addr", word_address_dest, a);
  endtask
  task automatic wait_ready(input string name);
    int k = 0;
    while (!line_ready && k < 20) begin
      tick();
      k++;
    end
    check(name, 32'(line_ready), 32'd1);
  endtask
  task automatic rd_check(input logic [4:0] idx, input logic [31:0] exp);
    rd_word_idx = idx;
    tick();
    rd_q.push_back(exp);
    @(negedge clk);
    #1;
  endtask
  initial begin
    repeat (3) tick();
    nrst = 1'b1;
    tick();
    check("rst_read_en", 32'(read_en), 32'd0);
    check("rst_line_ready", 32'(line_ready), 32'd0);
    check("rst_addr", word_address_dest, 32'd0);
    pulse_fs();
    repeat (5) tick();
    check("pre_rst_read_en", 32'(read_en), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("async_rd_word", rd_word, 32'd0);
    check("async_read_en", 32'(read_en), 32'd0);
    check("async_addr", word_address_dest, 32'd0);
    check("async_byte_sel", 32'(byte_select), 32'd0);
    check("async_line_ready", 32'(line_ready), 32'd0);
    check("async_underrun", 32'(underrun), 32'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (3) tick();
    check("post_rst_read_en", 32'(read_en), 32'd0);
    pulse_fs();
    expect_addrs(0, 39);
    wait_drain("drain_frame1");
    check("autoswap_ready", 32'(line_ready), 32'd1);
    tick();
    check("full_read_en", 32'(read_en), 32'd0);
    check("full_byte_sel", 32'(byte_select), 32'd0);
    rd_check(5'd5, 32'h1000_0005);
    rd_check(5'd25, 32'd0);
    rd_check(5'd19, 32'h1000_0013);
    tick();
    pulse_fs();
    expect_addrs(0, 39);
    wait_addr(32'd22);
    tick();
    SRAM_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("busy_addr", word_address_dest, 32'd23);
      check("busy_byte_sel", 32'(byte_select), 32'hF);
    end
    tick();
    SRAM_busy = 1'b0;
    wait_drain("drain_busy");
    tick();
    pulse_ld();
    check("swap_no_underrun", 32'(underrun), 32'd0);
    check("swap_line_ready", 32'(line_ready), 32'd1);
    rd_check(5'd3, 32'h1000_0017);
    tick();
    pulse_fs();
    expect_addrs(0, 39);
    wait_addr(32'd27);
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
    check("underrun_pulse", 32'(underrun), 32'd1);
    check("underrun_line_ready", 32'(line_ready), 32'd0);
    tick();
    check("underrun_one_cycle", 32'(underrun), 32'd0);
    rd_check(5'd5, 32'd0);
    wait_drain("drain_underrun");
    wait_ready("underrun_autoswap");
    rd_check(5'd0, 32'h1000_0014);
    repeat (25) tick();
    pulse_ld();
    wait_addr(32'd63);
    frame_start = 1'b1;
    line_done = 1'b1;
    tick();
    frame_start = 1'b0;
    line_done = 1'b0;
    expect_addrs(0, 19);
    check("fs_ld_no_underrun", 32'(underrun), 32'd0);
    check("fs_ld_line_ready", 32'(line_ready), 32'd0);
    wait_drain("drain_restart");
    check("reload_not_ready", 32'(line_ready), 32'd0);
    wait_ready("reload_ready");
    rd_check(5'd7, 32'h1000_0007);
    fs2 = 1'b1;
    tick();
    fs2 = 1'b0;
    repeat (50) tick();
    check("l2_full_read_en", 32'(re2), 32'd0);
    check("l2_full_ready", 32'(line_ready2), 32'd1);
    ld2 = 1'b1;
    tick();
    ld2 = 1'b0;
    check("l2_swap_ready", 32'(line_ready2), 32'd1);
    check("l2_idle_read_en", 32'(re2), 32'd0);
    rd_word_idx = 5'd1;
    tick();
    check("l2_rd_word", rd_word2, 32'h1000_0015);
    ld2 = 1'b1;
    tick();
    ld2 = 1'b0;
    check("l2_eof_ready", 32'(line_ready2), 32'd0);
    check("l2_eof_underrun", 32'(underrun2), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("l2_no_fetch", 32'(re2), 32'd0);
    end
    check("l2_black", rd_word2, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
